// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve slice: ALU/compare opcodes
// (same values the B-type decoder emits) and the fall-through PC step.
package branch_resolve_unit_pkg;

  localparam int PC_STEP = 4;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_XOR  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_NOP = 3'd0,
    CMP_EQ  = 3'd1,
    CMP_NE  = 3'd2,
    CMP_LT  = 3'd3,
    CMP_GE  = 3'd4,
    CMP_LTU = 3'd5,
    CMP_GEU = 3'd6
  } cmp_op_e;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// branch_cmp: combinational branch condition from ALU result and cmp_op.
// Ports: alu_res (XLEN), cmp_op (3) in; taken out. NOP/undefined -> 0.
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] alu_res,
  input  logic [2:0]      cmp_op,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (cmp_op)
      CMP_EQ:  taken = (alu_res == '0);
      CMP_NE:  taken = (alu_res != '0);
      CMP_LT,
      CMP_LTU: taken = alu_res[0];
      CMP_GE,
      CMP_GEU: taken = ~alu_res[0];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: S1 registers operands/ALU result, S2
// registers taken/next_pc. valid/ready in and out, flush, async rst.
// Ports: clk, rst, flush, in_valid/in_ready, pc, rs1_data, rs2_data,
//   immediate, alu_op, cmp_op, out_valid/out_ready, taken, redirect,
//   next_pc, misalign. Macro BRU_MISALIGN_TRAP_EN enables the trap.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] immediate,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      cmp_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            redirect,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_pc_q, s1_pc_d;
  logic [XLEN-1:0] s1_imm_q, s1_imm_d;
  logic [XLEN-1:0] s1_res_q, s1_res_d;
  logic [2:0]      s1_cmp_q, s1_cmp_d;

  logic            s2_valid_q, s2_valid_d;
  logic            taken_q, taken_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] npc_q, npc_d;

  logic            s2_adv;
  logic            accept;
  logic            load_s2;
  logic            cmp_taken;
  logic            mis;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign accept   = in_valid & in_ready & ~flush;
  assign load_s2  = s1_valid_q & s2_adv;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_XOR:  alu_res = rs1_data ^ rs2_data;
      ALU_SLT:  alu_res[0] = $signed(rs1_data) < $signed(rs2_data);
      ALU_SLTU: alu_res[0] = rs1_data < rs2_data;
      default:  alu_res = '0;
    endcase
  end

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .alu_res (s1_res_q),
    .cmp_op  (s1_cmp_q),
    .taken   (cmp_taken)
  );

  assign target = s1_pc_q + s1_imm_q;
  assign fall   = s1_pc_q + XLEN'(PC_STEP);

`ifdef BRU_MISALIGN_TRAP_EN
  assign mis = cmp_taken & (target[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pc_d    = s1_pc_q;
    s1_imm_d   = s1_imm_q;
    s1_res_d   = s1_res_q;
    s1_cmp_d   = s1_cmp_q;
    if (s2_adv) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_pc_d    = pc;
      s1_imm_d   = immediate;
      s1_res_d   = alu_res;
      s1_cmp_d   = cmp_op;
    end
    if (flush) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    taken_d    = taken_q;
    redirect_d = redirect_q;
    misalign_d = misalign_q;
    npc_d      = npc_q;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (load_s2) begin
      taken_d    = cmp_taken;
      redirect_d = cmp_taken & ~mis;
      misalign_d = mis;
      npc_d      = cmp_taken ? target : fall;
    end
    if (flush) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
      s1_imm_q   <= '0;
      s1_res_q   <= '0;
      s1_cmp_q   <= '0;
      s2_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      npc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pc_q    <= s1_pc_d;
      s1_imm_q   <= s1_imm_d;
      s1_res_q   <= s1_res_d;
      s1_cmp_q   <= s1_cmp_d;
      s2_valid_q <= s2_valid_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      npc_q      <= npc_d;
    end
  end

  // Gate with valid so a flushed/empty S2 never redirects fetch.
  assign out_valid = s2_valid_q;
  assign taken     = taken_q;
  assign redirect  = s2_valid_q & redirect_q;
  assign misalign  = s2_valid_q & misalign_q;
  assign next_pc   = npc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branch vectors,
// back-to-back, backpressure, flush and misalign cases.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pc, rs1_data, rs2_data, immediate, next_pc;
  logic [3:0]  alu_op;
  logic [2:0]  cmp_op;
  logic        taken, redirect, misalign;

  branch_resolve_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .immediate(immediate), .alu_op(alu_op), .cmp_op(cmp_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .redirect(redirect),
    .next_pc(next_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tk;
    logic [31:0] npc;
    logic        rd;
    logic        ms;
  } exp_t;

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [3:0]  aop;
    logic [2:0]  cop;
    exp_t        e;
  } vec_t;

  vec_t vt[10];
  exp_t exp_cur;
  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Input side of the scoreboard: an accept happens at the next edge
  // whenever these are true at the negedge.
  always @(negedge clk)
    if (!rst && in_valid && in_ready && !flush)
      sb.push_back(exp_cur);

  // Output monitor.
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got npc %h want none", next_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if ({taken, next_pc, redirect, misalign} !== e) begin
          fails++;
          $display("FAIL result: got tk=%b npc=%h rd=%b ms=%b want tk=%b npc=%h rd=%b ms=%b",
                   taken, next_pc, redirect, misalign,
                   e.tk, e.npc, e.rd, e.ms);
        end
      end
    end

  task automatic apply(input int i);
    pc        = vt[i].pc;
    rs1_data  = vt[i].rs1;
    rs2_data  = vt[i].rs2;
    immediate = vt[i].imm;
    alu_op    = vt[i].aop;
    cmp_op    = vt[i].cop;
    exp_cur   = vt[i].e;
  endtask

  task automatic send(input int i);
    int n;
    apply(i);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mis_rd, mis_ms;
`ifdef BRU_MISALIGN_TRAP_EN
    mis_rd = 1'b0; mis_ms = 1'b1;
`else
    mis_rd = 1'b1; mis_ms = 1'b0;
`endif
    vt[0] = '{32'h100, 32'd5, 32'd5, 32'h10, ALU_XOR, CMP_EQ,
              '{1'b1, 32'h110, 1'b1, 1'b0}};
    vt[1] = '{32'h200, 32'hFFFFFFFF, 32'd1, 32'h20, ALU_SLT, CMP_LT,
              '{1'b1, 32'h220, 1'b1, 1'b0}};
    vt[2] = '{32'h300, 32'hFFFFFFFF, 32'd1, 32'h20, ALU_SLTU, CMP_LTU,
              '{1'b0, 32'h304, 1'b0, 1'b0}};
    vt[3] = '{32'h400, 32'd7, 32'd7, 32'h40, ALU_XOR, CMP_NE,
              '{1'b0, 32'h404, 1'b0, 1'b0}};
    vt[4] = '{32'h500, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFF8, ALU_SLT, CMP_GE,
              '{1'b1, 32'h4F8, 1'b1, 1'b0}};
    vt[5] = '{32'h600, 32'd3, 32'hFFFFFFFE, 32'h8, ALU_SLTU, CMP_GEU,
              '{1'b0, 32'h604, 1'b0, 1'b0}};
    vt[6] = '{32'hFFFFFFF0, 32'd1, 32'd1, 32'h20, ALU_XOR, CMP_EQ,
              '{1'b1, 32'h10, 1'b1, 1'b0}};
    vt[7] = '{32'h700, 32'd0, 32'd0, 32'h10, ALU_XOR, CMP_NOP,
              '{1'b0, 32'h704, 1'b0, 1'b0}};
    vt[8] = '{32'h100, 32'd9, 32'd9, 32'h6, ALU_XOR, CMP_EQ,
              '{1'b1, 32'h106, mis_rd, mis_ms}};
    vt[9] = '{32'h800, 32'd1, 32'd2, 32'hC, ALU_XOR, CMP_NE,
              '{1'b1, 32'h80C, 1'b1, 1'b0}};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    apply(0);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_next_pc", next_pc, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Single BEQ: result two cycles after the accept cycle.
    send(0);
    @(negedge clk);
    chk("lat_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_c2", {31'd0, out_valid}, 32'd1);
    idle(2);

    send(1); idle(3);
    send(2); idle(3);

    // Back-to-back: 4 accepts, 4 consecutive results.
    pop_cyc.delete();
    for (int i = 3; i <= 6; i++) send(i);
    idle(5);
    chk("b2b_count", pop_cyc.size(), 32'd4);
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_gap", pop_cyc[i] - pop_cyc[i-1], 32'd1);

    send(7); idle(3);
    send(8); idle(3);
    send(9); idle(3);

    // Backpressure: fill both stages, stall 3 cycles, release.
    out_ready = 1'b0;
    send(0);
    send(1);
    apply(2);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_next_pc", next_pc, 32'h110);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(5);
    chk("bp_drained", sb.size(), 32'd0);

    // Flush with both stages full; the offered input must vanish.
    out_ready = 1'b0;
    send(3);
    send(4);
    @(negedge clk);
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    apply(9);
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_redirect", {31'd0, redirect}, 32'd0);
    pop_cyc.delete();
    idle(5);
    chk("fl_no_output", pop_cyc.size(), 32'd0);

    send(9); idle(4);
    chk("final_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
